// File: rtl/nn_stream_pkg.sv
// rtl/nn_stream_pkg.sv - stream constants and controller state shared by source, perceptron and layer controller
`timescale 1ns/1ps
package nn_stream_pkg;

  localparam int DATA_W    = 32;
  localparam int IMG_WORDS = 784;
  localparam int ADDR_STEP = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } stream_state_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - 2-entry registered FIFO; an optional last side-bit travels as the top data bit
`timescale 1ns/1ps
module stream_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/x_stream_source.sv
// rtl/x_stream_source.sv - streams one image vector from the pixel BRAM onto the x_* link
// X_STREAM_TLAST_EN: when defined, x_tlast marks word N_WORDS-1 via a FIFO side-bit.
`timescale 1ns/1ps
module x_stream_source #(
  parameter int N_WORDS   = nn_stream_pkg::IMG_WORDS,
  parameter int DATA_W    = nn_stream_pkg::DATA_W,
  parameter int ADDR_W    = 32,
  parameter int ADDR_STEP = nn_stream_pkg::ADDR_STEP
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] x_tdata,
  output logic              x_tvalid,
  input  logic              x_tready,
  output logic              x_tlast,
  output logic              busy,
  output logic              done
);

  import nn_stream_pkg::*;

  localparam int IDX_W = $clog2(N_WORDS + 1);
`ifdef X_STREAM_TLAST_EN
  localparam int LAST_W = 1;
`else
  localparam int LAST_W = 0;
`endif
  localparam int FIFO_W = DATA_W + LAST_W;

  stream_state_t     state;
  stream_state_t     state_n;
  logic              start_q;
  logic              start_rise;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  beat_cnt;
  logic              in_flight;
  logic              pop;
  logic              room;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occ;
  logic [FIFO_W-1:0] push_word;
  logic [FIFO_W-1:0] head_word;

  assign start_rise = start & ~start_q;
  assign pop        = x_tvalid & x_tready;

  // Slots already claimed (stored + in flight) minus this cycle's pop must leave one free.
  assign room = fifo_full ? pop
              : (({1'b0, occ} + {2'b0, in_flight}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    bram_en = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = STREAM;
        end
      end
      STREAM: begin
        busy    = 1'b1;
        bram_en = (rd_idx < IDX_W'(N_WORDS)) & room;
        if (pop && (beat_cnt == IDX_W'(N_WORDS - 1))) begin
          state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      start_q   <= 1'b0;
      rd_idx    <= '0;
      beat_cnt  <= '0;
      in_flight <= 1'b0;
    end else begin
      start_q   <= start;
      in_flight <= bram_en;
      if ((state == IDLE) && start_rise) begin
        rd_idx   <= '0;
        beat_cnt <= '0;
      end else begin
        if (bram_en) begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
        if (pop && (beat_cnt != IDX_W'(N_WORDS - 1))) begin
          beat_cnt <= beat_cnt + IDX_W'(1);
        end
      end
    end
  end

  assign bram_addr = ADDR_W'(rd_idx) * ADDR_W'(ADDR_STEP);

  // The word landing now was issued last cycle, so it is the last one when rd_idx has reached N_WORDS.
`ifdef X_STREAM_TLAST_EN
  assign push_word = {(rd_idx == IDX_W'(N_WORDS)), bram_dout};
  assign x_tlast   = x_tvalid & head_word[DATA_W];
`else
  assign push_word = bram_dout;
  assign x_tlast   = 1'b0;
`endif

  stream_fifo2 #(
    .W(FIFO_W)
  ) u_fifo (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .push      (in_flight),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occ)
  );

  assign x_tvalid = ~fifo_empty;
  assign x_tdata  = head_word[DATA_W-1:0];

endmodule

// File: tb/tb_x_stream_source.sv
// tb/tb_x_stream_source.sv - scoreboard bench for x_stream_source (784-word and 3-word instances)
`timescale 1ns/1ps
module tb_x_stream_source;

  localparam int N = 784;

  typedef struct {
    logic [31:0] d;
    logic        l;
    bit          fin;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, x_tready, bram_en, x_tvalid, x_tlast, busy, done;
  logic [31:0] bram_addr, x_tdata;
  logic [31:0] bram_dout = '0;
  logic        start3, x_tready3, bram_en3, x_tvalid3, x_tlast3, busy3, done3;
  logic [31:0] bram_addr3, x_tdata3;
  logic [31:0] bram_dout3 = '0;

  int    vectors = 0;
  int    miscompares = 0;
  beat_t exp_q[$];
  int    n_issued = 0;
  int    n_popped = 0;
  int    beats3 = 0;
  int    done_cnt3 = 0;

  always #5 clk = ~clk;

  x_stream_source dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_dout(bram_dout),
    .x_tdata(x_tdata), .x_tvalid(x_tvalid), .x_tready(x_tready), .x_tlast(x_tlast),
    .busy(busy), .done(done)
  );

  x_stream_source #(.N_WORDS(3)) dut3 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start3),
    .bram_addr(bram_addr3), .bram_en(bram_en3), .bram_dout(bram_dout3),
    .x_tdata(x_tdata3), .x_tvalid(x_tvalid3), .x_tready(x_tready3), .x_tlast(x_tlast3),
    .busy(busy3), .done(done3)
  );

  // BRAM models: word i holds i+1 (main) and i+11 (small instance), one-cycle latency.
  always @(posedge clk) if (bram_en)  bram_dout  <= bram_addr / 4 + 1;
  always @(posedge clk) if (bram_en3) bram_dout3 <= bram_addr3 / 4 + 11;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the main instance: scoreboard, hold stability, issue room, address sequence, done timing.
  bit          stall_prev = 0;
  bit          last_beat_prev = 0;
  logic [31:0] data_prev = '0;
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst_n) begin
      stall_prev     = 0;
      last_beat_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", x_tvalid, 1);
        chk("hold_data", x_tdata, data_prev);
      end
      chk("done_timing", done, last_beat_prev);
      if (done) chk("busy_in_done", busy, 0);
      if (bram_en) begin
        chk("issue_room", ((n_issued - n_popped - int'(x_tvalid && x_tready)) < 2), 1);
        chk("issue_addr", bram_addr, n_issued * 4);
      end
      if (!x_tvalid) chk("tlast_idle", x_tlast, 0);
      last_beat_prev = 0;
      if (x_tvalid && x_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat: got %0d, expected no beat", x_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", x_tdata, e.d);
          chk("beat_last", x_tlast, e.l);
          last_beat_prev = e.fin;
        end
        n_popped++;
      end
      stall_prev = x_tvalid && !x_tready;
      data_prev  = x_tdata;
      if (bram_en) n_issued++;
    end
  end

  always @(negedge clk) begin : mon3
    if (rst_n) begin
      if (x_tvalid3 && x_tready3) begin
        chk("n3_data", x_tdata3, beats3 + 11);
`ifdef X_STREAM_TLAST_EN
        chk("n3_last", x_tlast3, beats3 == 2);
`else
        chk("n3_last", x_tlast3, 0);
`endif
        beats3++;
      end
      if (done3) begin
        done_cnt3++;
        chk("n3_busy_with_done", busy3, 0);
      end
    end
  end

  task automatic push_vector();
    beat_t b;
    for (int i = 1; i <= N; i++) begin
      b.d = i;
`ifdef X_STREAM_TLAST_EN
      b.l = (i == N);
`else
      b.l = 1'b0;
`endif
      b.fin = (i == N);
      exp_q.push_back(b);
    end
  endtask

  // Start rise, then check first-read and first-valid latency.
  task automatic begin_vector();
    push_vector();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_issued = 0;
    n_popped = 0;
    start = 1'b1;
    @(negedge clk);
    chk("e0_bram_en", bram_en, 1);
    chk("e0_bram_addr", bram_addr, 0);
    chk("e0_valid", x_tvalid, 0);
    chk("e0_busy", busy, 1);
    @(negedge clk);
    chk("e1_valid", x_tvalid, 0);
    @(negedge clk);
    chk("e2_valid", x_tvalid, 1);
  endtask

  task automatic wait_done(input int limit, input bit rnd);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rnd) x_tready = 1'($urandom_range(0, 1));
      if (done) seen = 1;
    end
    chk("done_seen", seen, 1);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    x_tready = 1'b1;
  endtask

  task automatic wait_beats(input int n);
    bit ok = 0;
    for (int i = 0; i < 4 * N && !ok; i++) begin
      @(posedge clk);
      #1;
      if (n_popped >= n) ok = 1;
    end
    chk("reach_beat", ok, 1);
  endtask

  initial begin : stim
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0; start = 1'b0; x_tready = 1'b0; start3 = 1'b0; x_tready3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", x_tvalid, 0);
    chk("rst_tlast", x_tlast, 0);
    chk("rst_tdata", x_tdata, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    // Full-rate vector.
    @(posedge clk); #1; x_tready = 1'b1;
    begin_vector();
    wait_done(N + 50, 0);

    // Random back-pressure.
    begin_vector();
    wait_done(8 * N, 1);

    // Ready held low for 20 cycles after first valid.
    @(posedge clk); #1; x_tready = 1'b0;
    begin_vector();
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("stall_reads", n_issued, 2);
    chk("stall_bram_en", bram_en, 0);
    x_tready = 1'b1;
    wait_done(N + 50, 0);

    // Second start rise mid-vector is ignored; a rise after done restarts at address 0.
    begin_vector();
    wait_beats(100);
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); chk("ignored_busy", busy, 1);
    wait_done(N + 50, 0);
    begin_vector();
    wait_done(N + 50, 0);

    // Asynchronous reset mid-vector.
    begin_vector();
    wait_beats(300);
    @(negedge clk); #1;
    chk("pre_rst_valid", x_tvalid, 1);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("arst_tvalid", x_tvalid, 0);
    chk("arst_tdata", x_tdata, 0);
    chk("arst_tlast", x_tlast, 0);
    chk("arst_bram_en", bram_en, 0);
    chk("arst_bram_addr", bram_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    exp_q.delete();
    n_issued = 0;
    n_popped = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1; rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_valid", x_tvalid, 0);
    chk("post_rst_bram_en", bram_en, 0);
    chk("post_rst_busy", busy, 0);
    begin_vector();
    wait_done(N + 50, 0);

    // Three-word instance with ready pattern 1,0,1,1.
    beats3 = 0;
    done_cnt3 = 0;
    @(negedge clk); start3 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      x_tready3 = pat[k % 4];
    end
    chk("n3_beats", beats3, 3);
    chk("n3_done_pulses", done_cnt3, 1);
    chk("n3_busy_after", busy3, 0);
    chk("n3_valid_after", x_tvalid3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
